// File: rtl/seq_slice_adder16_if.sv
// Handshake and operand/result bundle for the nibble-serial add/subtract unit.
// The master drives operands and out_ready; the slave drives results and in_ready.
interface seq_slice_adder16_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             Ofl;

   modport master (
      output in_valid, A, B, Cin, op_sub, out_ready,
      input  in_ready, out_valid, S, Cout, Ofl
   );

   modport slave (
      input  in_valid, A, B, Cin, op_sub, out_ready,
      output in_ready, out_valid, S, Cout, Ofl
   );
endinterface

// File: rtl/seq_slice_adder16.sv
// Multi-cycle add/subtract: one shared 4-bit adder slice walks the operands
// LS nibble first, carrying between slices in a register.

module fulladder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one slice per cycle, idx = nibble being added
// DONE  | result held with out_valid=1 until out_ready
module seq_slice_adder16 #(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst_n,
   seq_slice_adder16_if.slave bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] s_r;
   logic             carry;
   logic             cout_r;
   logic             ofl_r;
   logic [IW-1:0]    idx;

   logic             in_ready;
   logic             accept;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       sl_s;
   logic             sl_co;
   logic             sl_ofl;

   // in_ready depends on out_ready only, so a consumer release and a new
   // accept can share one cycle without a combinational loop through in_valid.
   assign in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign accept   = bus.in_valid & in_ready;

   assign a_nib = a_r[4*idx +: 4];
   assign b_nib = b_r[4*idx +: 4];

   fulladder4 u_slice (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry),
      .s  (sl_s),
      .co (sl_co)
   );

   // Only meaningful on the MS nibble, where bit 3 is the sign bit.
   assign sl_ofl = (a_nib[3] == b_nib[3]) & (sl_s[3] != a_nib[3]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         s_r    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ofl_r  <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  a_r   <= bus.A;
                  b_r   <= bus.B ^ {WIDTH{bus.op_sub}};
                  carry <= bus.op_sub ? 1'b1 : bus.Cin;
                  idx   <= '0;
                  state <= BUSY;
               end else if (state == DONE && bus.out_ready) begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               s_r[4*idx +: 4] <= sl_s;
               carry           <= sl_co;
               if (idx == LAST) begin
                  cout_r <= sl_co;
                  ofl_r  <= sl_ofl;
                  idx    <= '0;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.S         = s_r;
   assign bus.Cout      = cout_r;
   assign bus.Ofl       = ofl_r;
endmodule

// File: tb/tb_seq_slice_adder16.sv
// Directed bench for seq_slice_adder16: arithmetic vectors, latency,
// back-pressure with same-cycle re-accept, and reset mid-operation.
module tb_seq_slice_adder16;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   logic [15:0] held_s;

   seq_slice_adder16_if #(.WIDTH(16)) bus ();

   seq_slice_adder16 #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for out_valid; returns cycles counted since the accept edge.
   task automatic wait_result(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
   endtask

   // Accept one operation, scramble inputs during BUSY, check result and latency.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] exp_s, input logic exp_c, input logic exp_o);
      bus.A = a; bus.B = b; bus.Cin = cin; bus.op_sub = sub; bus.in_valid = 1'b1;
      #1;
      check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.A = 16'hDEAD; bus.B = 16'hBEEF; bus.Cin = 1'b1; bus.op_sub = ~sub;
      bus.in_valid = 1'b1;
      #1;
      check({tag, ".busy_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b0;
      wait_result(cyc);
      check({tag, ".latency"}, cyc, 32'd4);
      check({tag, ".S"}, {16'd0, bus.S}, {16'd0, exp_s});
      check({tag, ".Cout"}, {31'd0, bus.Cout}, {31'd0, exp_c});
      check({tag, ".Ofl"}, {31'd0, bus.Ofl}, {31'd0, exp_o});
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, ".released"}, {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
      bus.op_sub = 1'b0; bus.out_ready = 1'b0;
      repeat (2) step();
      check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst.S", {16'd0, bus.S}, 32'd0);
      check("rst.Cout", {31'd0, bus.Cout}, 32'd0);
      check("rst.Ofl", {31'd0, bus.Ofl}, 32'd0);
      rst_n = 1'b1;
      step();
      check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

      run_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("ripple_ci",16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("borrow",   16'h0005, 16'h0007, 1'bx, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // Back-pressure then same-cycle release and accept.
      bus.A = 16'h0100; bus.B = 16'h0023; bus.Cin = 1'b1; bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wait_result(cyc);
      check("hs.latency", cyc, 32'd4);
      check("hs.S", {16'd0, bus.S}, 32'h0124);
      held_s = bus.S;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hs.hold_valid", {31'd0, bus.out_valid}, 32'd1);
         check("hs.hold_S", {16'd0, bus.S}, {16'd0, held_s});
         check("hs.hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      bus.A = 16'h0002; bus.B = 16'h0003; bus.Cin = 1'b0; bus.op_sub = 1'b0;
      #1;
      check("hs.release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      check("hs.reaccept_busy", {31'd0, bus.out_valid}, 32'd0);
      wait_result(cyc);
      check("hs.b2b_latency", cyc, 32'd4);
      check("hs.b2b_S", {16'd0, bus.S}, 32'h0005);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // Reset two cycles after an accept discards the operation.
      bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0; bus.op_sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check("rstmid.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rstmid.S", {16'd0, bus.S}, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      check("rstmid.in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         check("rstmid.no_stale", {31'd0, bus.out_valid}, 32'd0);
      end
      check("rstmid.S_after", {16'd0, bus.S}, 32'd0);

      run_op("post_rst", 16'hA5A5, 16'h0F0F, 1'b0, 1'b1, 16'h9696, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
